// File: rtl/next_pc_unit_if.sv
// Fetch-side instruction-memory request bus: address, handshake and wrong-path discard.
// The next-PC generator is the master; the instruction memory / Fetch stage is the slave.
interface next_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_plus4_f;
    logic            discard_f;

    modport master (
        output imem_req_valid,
        output pc_f,
        output pc_plus4_f,
        output discard_f,
        input  imem_req_ready
    );

    modport slave (
        input  imem_req_valid,
        input  pc_f,
        input  pc_plus4_f,
        input  discard_f,
        output imem_req_ready
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC generator: owns the fetch PC, resolves jumps/branches from Execute and redirects.
// Latency: redirect is combinational; new pc_f one cycle later, or after ready when pending.
// Backpressure: a redirect that meets an unaccepted request parks in PEND until ready.
// Optional PC_STATS_EN adds branch/taken counters.
module next_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    next_pc_unit_if.master  imem,
    input  logic            ex_valid,
    input  logic [1:0]      ex_pc_src,
    input  logic [2:0]      ex_cond,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    output logic            redirect,
    output logic            flush_d,
    output logic            flush_e,
    output logic            misalign_trap
`ifdef PC_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken
`endif
);

    typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] tgt_pc_imm;
    logic [XLEN-1:0] tgt_rs1_imm;
    logic [XLEN-1:0] target;
    logic            cond_true;
    logic            is_jump;
    logic            is_branch;
    logic            taken;
    logic            tgt_misaligned;
    logic            req_vld;
    logic            discard;

    assign pc_plus4    = pc_q + XLEN'(4);
    assign tgt_pc_imm  = ex_pc + ex_imm;
    assign tgt_rs1_imm = (ex_rs1 + ex_imm) & ~XLEN'(1);
    assign target      = (ex_pc_src == 2'd2) ? tgt_rs1_imm : tgt_pc_imm;
    assign tgt_misaligned = (target[1:0] != 2'b00);

    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            3'd1:    cond_true = (ex_rs1 == ex_rs2);
            3'd2:    cond_true = (ex_rs1 != ex_rs2);
            3'd3:    cond_true = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'd4:    cond_true = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'd5:    cond_true = (ex_rs1 <  ex_rs2);
            3'd6:    cond_true = (ex_rs1 >= ex_rs2);
            default: cond_true = 1'b0;
        endcase
    end

    assign is_jump   = (ex_pc_src == 2'd1) || (ex_pc_src == 2'd2);
    assign is_branch = (ex_pc_src == 2'd3);
    assign taken     = ex_valid && (is_jump || (is_branch && cond_true));
    assign redirect  = !reset && taken && (state_q != HALT);
    assign flush_d   = redirect;
    assign flush_e   = redirect;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        req_vld   = 1'b0;
        discard   = 1'b0;
        case (state_q)
            RUN: begin
                req_vld = !stall_f;
                if (redirect) begin
                    if (tgt_misaligned) begin
                        state_d = HALT;
                        pc_d    = target;
                    end else if (req_vld && !imem.imem_req_ready) begin
                        state_d   = PEND;
                        pend_pc_d = target;
                    end else begin
                        pc_d = target;
                    end
                end else if (req_vld && imem.imem_req_ready) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                // Address must stay stable until accepted, so stall_f is ignored here.
                req_vld = 1'b1;
                if (imem.imem_req_ready) begin
                    discard = 1'b1;
                    state_d = RUN;
                    pc_d    = redirect ? target : pend_pc_q;
                end else if (redirect) begin
                    pend_pc_d = target;
                end
                if (redirect && tgt_misaligned) begin
                    state_d = HALT;
                    pc_d    = target;
                end
            end
            default: begin
                req_vld = 1'b0;
            end
        endcase
        if (reset) begin
            req_vld = 1'b0;
            discard = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_VECTOR;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign imem.imem_req_valid = req_vld;
    assign imem.pc_f           = pc_q;
    assign imem.pc_plus4_f     = pc_plus4;
    assign imem.discard_f      = discard;
    assign misalign_trap       = (state_q == HALT);

`ifdef PC_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_taken_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_taken_q    <= '0;
        end else begin
            if (ex_valid && is_branch) stat_branches_q <= stat_branches_q + 32'd1;
            if (taken)                 stat_taken_q    <= stat_taken_q + 32'd1;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: a 32-bit instance (RESET_VECTOR 0x1000) and a 64-bit instance.
module tb_next_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 32-bit instance
    logic        rst32, stall32, exv32;
    logic [1:0]  src32;
    logic [2:0]  cond32;
    logic [31:0] pc32, imm32, rs1_32, rs2_32;
    logic        redir32, fd32, fe32, mis32;
    next_pc_unit_if #(.XLEN(32)) if32 ();

    // 64-bit instance
    logic        rst64, stall64, exv64;
    logic [1:0]  src64;
    logic [2:0]  cond64;
    logic [63:0] pc64, imm64, rs1_64, rs2_64;
    logic        redir64, fd64, fe64, mis64;
    next_pc_unit_if #(.XLEN(64)) if64 ();

`ifdef PC_STATS_EN
    logic [31:0] sb32, st32, sb64, st64;
`endif

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_1000)) u32 (
        .clk(clk), .reset(rst32), .stall_f(stall32), .imem(if32.master),
        .ex_valid(exv32), .ex_pc_src(src32), .ex_cond(cond32),
        .ex_pc(pc32), .ex_imm(imm32), .ex_rs1(rs1_32), .ex_rs2(rs2_32),
        .redirect(redir32), .flush_d(fd32), .flush_e(fe32), .misalign_trap(mis32)
`ifdef PC_STATS_EN
        , .stat_branches(sb32), .stat_taken(st32)
`endif
    );

    next_pc_unit #(.XLEN(64)) u64 (
        .clk(clk), .reset(rst64), .stall_f(stall64), .imem(if64.master),
        .ex_valid(exv64), .ex_pc_src(src64), .ex_cond(cond64),
        .ex_pc(pc64), .ex_imm(imm64), .ex_rs1(rs1_64), .ex_rs2(rs2_64),
        .redirect(redir64), .flush_d(fd64), .flush_e(fe64), .misalign_trap(mis64)
`ifdef PC_STATS_EN
        , .stat_branches(sb64), .stat_taken(st64)
`endif
    );

    typedef struct {
        logic        vld;
        logic [1:0]  src;
        logic [2:0]  cond;
        logic [31:0] pc, imm, rs1, rs2;
        logic        taken;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [15];

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [1:0] s, input logic [2:0] c,
                          input logic [31:0] p, input logic [31:0] i,
                          input logic [31:0] a, input logic [31:0] b);
        exv32 = v; src32 = s; cond32 = c; pc32 = p; imm32 = i; rs1_32 = a; rs2_32 = b;
    endtask

    logic [31:0] pcb;

    initial begin
        //         vld  src   cond  pc            imm           rs1           rs2           taken tgt
        vecs[0]  = '{1'b1, 2'd3, 3'd3, 32'h0000_2000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_1FF0};
        vecs[1]  = '{1'b1, 2'd3, 3'd5, 32'h0000_2000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 2'd3, 3'd1, 32'h0000_0100, 32'h0000_0020, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0120};
        vecs[3]  = '{1'b1, 2'd3, 3'd2, 32'h0000_0100, 32'h0000_0020, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 2'd3, 3'd4, 32'h0000_0200, 32'h0000_0008, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h0000_0208};
        vecs[5]  = '{1'b1, 2'd3, 3'd6, 32'h0000_0200, 32'h0000_0008, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 2'd3, 3'd0, 32'h0000_0300, 32'h0000_0008, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 2'd3, 3'd7, 32'h0000_0300, 32'h0000_0008, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 2'd1, 3'd0, 32'h0000_0500, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0600};
        vecs[9]  = '{1'b1, 2'd2, 3'd0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0701, 32'h0000_0000, 1'b1, 32'h0000_0710};
        vecs[10] = '{1'b1, 2'd0, 3'd1, 32'h0000_0900, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 2'd3, 3'd4, 32'h0000_0800, 32'h0000_0004, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b1, 32'h0000_0804};
        vecs[12] = '{1'b0, 2'd1, 3'd0, 32'h0000_0A00, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 2'd1, 3'd0, 32'hFFFF_FFF0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
        vecs[14] = '{1'b1, 2'd0, 3'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0};

        rst32 = 1'b1; stall32 = 1'b0; if32.imem_req_ready = 1'b1;
        set_ex(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst64 = 1'b1; stall64 = 1'b0; if64.imem_req_ready = 1'b1;
        exv64 = 1'b0; src64 = 2'd0; cond64 = 3'd0; pc64 = '0; imm64 = '0; rs1_64 = '0; rs2_64 = '0;

        // Reset state
        step();
        chk1("valid_in_reset", if32.imem_req_valid, 1'b0);
        step();
        chk32("reset_pc", if32.pc_f, 32'h0000_1000);
        chk1("reset_valid", if32.imem_req_valid, 1'b0);
        chk1("reset_redirect", redir32, 1'b0);
        chk1("reset_discard", if32.discard_f, 1'b0);
        chk1("reset_trap", mis32, 1'b0);
        rst32 = 1'b0; rst64 = 1'b0;
        #1;
        chk1("valid_after_reset", if32.imem_req_valid, 1'b1);
        chk32("pc_after_reset", if32.pc_f, 32'h0000_1000);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk32("seq_pc", if32.pc_f, 32'h0000_1000 + 32'(4 * k));
            chk1("seq_flush_d", fd32, 1'b0);
            chk1("seq_flush_e", fe32, 1'b0);
        end

        // Table of jump/branch resolutions, applied with ready=1
        for (int i = 0; i < 15; i++) begin
            set_ex(vecs[i].vld, vecs[i].src, vecs[i].cond, vecs[i].pc, vecs[i].imm,
                   vecs[i].rs1, vecs[i].rs2);
            #1;
            chk1($sformatf("vec%0d_redirect", i), redir32, vecs[i].taken);
            chk1($sformatf("vec%0d_flush_d", i), fd32, vecs[i].taken);
            pcb = if32.pc_f;
            step();
            chk32($sformatf("vec%0d_pc", i), if32.pc_f, vecs[i].taken ? vecs[i].tgt : pcb + 32'd4);
            chk32($sformatf("vec%0d_pc4", i), if32.pc_plus4_f, if32.pc_f + 32'd4);
        end
        chk32("wrap32_pc", if32.pc_f, 32'h0);
        exv32 = 1'b0;

        // Stall without redirect, then stall with redirect
        stall32 = 1'b1;
        #1;
        chk1("stall_valid", if32.imem_req_valid, 1'b0);
        pcb = if32.pc_f;
        step();
        chk32("stall_hold", if32.pc_f, pcb);
        set_ex(1'b1, 2'd1, 3'd0, 32'h0000_0900, 32'h0000_0040, 32'h0, 32'h0);
        #1;
        chk1("stall_redirect", redir32, 1'b1);
        step();
        chk32("stall_redirect_pc", if32.pc_f, 32'h0000_0940);
        stall32 = 1'b0; exv32 = 1'b0;

        // Jump_C while memory is not ready: park in PEND
        if32.imem_req_ready = 1'b0;
        set_ex(1'b1, 2'd2, 3'd0, 32'h0, 32'h0000_0004, 32'h0000_3001, 32'h0);
        pcb = if32.pc_f;
        #1;
        chk1("pend_redirect", redir32, 1'b1);
        step();
        exv32 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stall32 = (k == 1);
            #1;
            chk32("pend_hold", if32.pc_f, pcb);
            chk1("pend_valid", if32.imem_req_valid, 1'b1);
            chk1("pend_no_discard", if32.discard_f, 1'b0);
            step();
        end
        stall32 = 1'b0;
        if32.imem_req_ready = 1'b1;
        #1;
        chk1("pend_discard", if32.discard_f, 1'b1);
        step();
        chk32("pend_target", if32.pc_f, 32'h0000_3004);
        chk1("pend_discard_clear", if32.discard_f, 1'b0);

        // Newest redirect in PEND wins
        if32.imem_req_ready = 1'b0;
        set_ex(1'b1, 2'd1, 3'd0, 32'h0000_5000, 32'h0, 32'h0, 32'h0);
        step();
        set_ex(1'b1, 2'd1, 3'd0, 32'h0000_6000, 32'h0000_0010, 32'h0, 32'h0);
        #1;
        chk1("pend2_redirect", redir32, 1'b1);
        step();
        exv32 = 1'b0;
        if32.imem_req_ready = 1'b1;
        #1;
        chk1("pend2_discard", if32.discard_f, 1'b1);
        step();
        chk32("pend2_newest", if32.pc_f, 32'h0000_6010);

        // Reset while PEND: pending target dropped, no discard
        if32.imem_req_ready = 1'b0;
        set_ex(1'b1, 2'd1, 3'd0, 32'h0000_7000, 32'h0, 32'h0, 32'h0);
        step();
        exv32 = 1'b0;
        rst32 = 1'b1;
        if32.imem_req_ready = 1'b1;
        #1;
        chk1("rstpend_discard", if32.discard_f, 1'b0);
        step();
        chk32("rstpend_pc", if32.pc_f, 32'h0000_1000);
        rst32 = 1'b0;
        step();
        chk32("rstpend_resume", if32.pc_f, 32'h0000_1004);

        // Misaligned Jump_R target: trap and halt until reset
        set_ex(1'b1, 2'd1, 3'd0, 32'h0000_4000, 32'h0000_0002, 32'h0, 32'h0);
        #1;
        chk1("mis_redirect", redir32, 1'b1);
        chk1("mis_flush_e", fe32, 1'b1);
        step();
        exv32 = 1'b0;
        #1;
        chk1("mis_trap", mis32, 1'b1);
        chk1("mis_valid", if32.imem_req_valid, 1'b0);
        chk32("mis_pc", if32.pc_f, 32'h0000_4002);
        set_ex(1'b1, 2'd1, 3'd0, 32'h0000_0100, 32'h0, 32'h0, 32'h0);
        #1;
        chk1("halt_no_redirect", redir32, 1'b0);
        step();
        chk32("halt_pc_frozen", if32.pc_f, 32'h0000_4002);
        chk1("halt_trap_sticky", mis32, 1'b1);
        exv32 = 1'b0;
        rst32 = 1'b1;
        step();
        rst32 = 1'b0;
        #1;
        chk1("halt_reset_trap", mis32, 1'b0);
        chk1("halt_reset_valid", if32.imem_req_valid, 1'b1);
        chk32("halt_reset_pc", if32.pc_f, 32'h0000_1000);

`ifdef PC_STATS_EN
        rst32 = 1'b1;
        step();
        rst32 = 1'b0;
        chk32("stat_branches_reset", sb32, 32'd0);
        chk32("stat_taken_reset", st32, 32'd0);
        set_ex(1'b1, 2'd3, 3'd1, 32'h100, 32'h20, 32'd5, 32'd5); step();
        set_ex(1'b1, 2'd3, 3'd2, 32'h100, 32'h20, 32'd5, 32'd5); step();
        set_ex(1'b1, 2'd3, 3'd3, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1); step();
        set_ex(1'b1, 2'd3, 3'd5, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1); step();
        set_ex(1'b1, 2'd3, 3'd0, 32'h300, 32'h20, 32'd1, 32'd1); step();
        set_ex(1'b1, 2'd1, 3'd0, 32'h400, 32'h40, 32'd0, 32'd0); step();
        exv32 = 1'b0;
        chk32("stat_branches", sb32, 32'd5);
        chk32("stat_taken", st32, 32'd3);
`endif

        // 64-bit: wrap from 2^64-4 to 0, then stall vs redirect
        exv64 = 1'b1; src64 = 2'd1;
        pc64 = 64'hFFFF_FFFF_FFFF_FFF0; imm64 = 64'h0000_0000_0000_000C;
        #1;
        chk1("x64_redirect", redir64, 1'b1);
        step();
        exv64 = 1'b0;
        chk64("x64_pc_top", if64.pc_f, 64'hFFFF_FFFF_FFFF_FFFC);
        chk64("x64_pc4_wrap", if64.pc_plus4_f, 64'h0);
        step();
        chk64("x64_wrap", if64.pc_f, 64'h0);
        chk1("x64_no_trap", mis64, 1'b0);
        stall64 = 1'b1;
        exv64 = 1'b1; pc64 = 64'h10; imm64 = 64'h10;
        #1;
        chk1("x64_stall_redirect", redir64, 1'b1);
        chk1("x64_stall_valid", if64.imem_req_valid, 1'b0);
        step();
        chk64("x64_stall_redirect_pc", if64.pc_f, 64'h20);
        stall64 = 1'b0; exv64 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised next-PC generator for the pipelined RISC-V core. It owns the fetch PC register and drives the instruction-memory request through a valid/ready handshake. It resolves jumps and all six conditional branches from Execute-stage operands and issues pipeline flushes on redirect. A redirect that arrives while a fetch request is outstanding is held until the memory accepts the request.

## Interface
- XLEN, 32: datapath/PC width; legal values 32 or 64.
- RESET_VECTOR, 0: PC loaded on reset, XLEN bits.

- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- stall_f  in  1  hazard unit holds Fetch; PC must not advance
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  instruction memory accepts request
- pc_f  out  XLEN  fetch address, registered
- pc_plus4_f  out  XLEN  pc_f + 4, modulo 2^XLEN
- ex_valid  in  1  Execute slot holds a real instruction
- ex_pc_src  in  2  0=PCp4, 1=Jump_R (PC+imm), 2=Jump_C (rs1+imm), 3=Branch_C
- ex_cond  in  3  0=NONE, 1=BEQ, 2=BNE, 3=BLT, 4=BGE, 5=BLTU, 6=BGEU; 7 is reserved and treated as NONE
- ex_pc, ex_imm, ex_rs1, ex_rs2  in  XLEN each  Execute-stage PC, sign-extended immediate, forwarded operands
- redirect  out  1  redirect taken this cycle (combinational)
- flush_d, flush_e  out  1  squash Decode and Execute; equal to redirect
- discard_f  out  1  the accepted request is wrong-path; Fetch drops its response
- misalign_trap  out  1  sticky flag for a target with bits [1:0] != 0

## Operation
- Target selection:
  - Jump_R uses ex_pc+ex_imm.
  - Jump_C uses (ex_rs1+ex_imm) with bit 0 cleared.
  - Branch_C uses ex_pc+ex_imm.
  - All target additions are XLEN-bit and wrap.
- Branch_C is taken when ex_cond is true:
  - EQ/NE compare full XLEN.
  - LT/GE use a signed compare.
  - LTU/GEU use an unsigned compare.
  - ex_cond NONE with Branch_C is never taken.
- redirect = ex_valid & (Jump_R | Jump_C | taken Branch_C) & state != HALT.
- FSM states:
  - RUN:
    - imem_req_valid=1 unless stall_f.
    - On handshake (valid & ready), pc_f <= pc_f+4.
    - On redirect with the request accepted, or no request pending, pc_f <= target and stay in RUN.
    - On redirect while valid & !ready, latch the target into pend_pc and go to PEND; pc_f is held.
  - PEND:
    - imem_req_valid=1 and pc_f is held, regardless of stall_f, so the address stays stable per the handshake rule.
    - On ready, pc_f <= pend_pc, discard_f=1 that cycle, and return to RUN.
    - A new redirect in PEND overwrites pend_pc; the newest redirect wins.
  - HALT:
    - Entered on a redirect whose target has bits [1:0] != 0. Jump_C is checked on bit 1 only, after bit 0 is cleared.
    - misalign_trap=1, imem_req_valid=0, pc_f frozen at the faulting instruction's target.
    - Flushes still fire in the entering cycle.
    - Left only by reset.
- Priority: reset > redirect > stall_f > sequential advance.
- stall_f with no redirect: pc_f held and imem_req_valid=0.

## Timing
- Reset values (cycle after reset high):
  - pc_f=RESET_VECTOR, state RUN, pend_pc=0.
  - imem_req_valid=0 while reset is high; it rises the first cycle after reset drops, unless stall_f.
  - redirect, flush_*, discard_f and misalign_trap are 0.
  - Counters, if present, are 0.
- Redirect is combinational from the E-stage inputs in cycle N. The new pc_f is visible in N+1 (RUN) or in the cycle after ready rises (PEND).
- Misprediction penalty is 2 bubbles: flush_d and flush_e in N.
- PC wrap: pc_f = 2^XLEN-4 advances to 0 with no flag.
- Reset mid-PEND: pend_pc is discarded and discard_f stays 0.

## Configuration
- PC_STATS_EN defined:
  - Adds outputs stat_branches and stat_taken, 32 bits each, wrapping, reset to 0.
  - stat_branches increments on every ex_valid Branch_C.
  - stat_taken increments on taken branches and jumps.
- Undefined: the ports and counters are absent, and the behaviour above is otherwise identical.

## Test plan
- Reset with RESET_VECTOR=0x1000, ready=1 for 3 cycles -> pc_f 0x1000, 0x1004, 0x1008, 0x100C; flushes 0.
- BLT with rs1=-1, rs2=1, ex_pc=0x2000, imm=-16 -> redirect=1; pc_f=0x1FF0 next cycle. The same operands with BLTU -> not taken.
- Jump_C with rs1=0x3001, imm=4, while ready=0 for 3 cycles:
  - State PEND; pc_f held for 3 cycles.
  - When ready rises: discard_f=1, then pc_f=0x3004.
- Jump_R target 0x4002 -> misalign_trap=1 and imem_req_valid=0 thereafter; reset clears both.
- XLEN=64, pc_f=0xFFFF_FFFF_FFFF_FFFC with a handshake -> pc_f=0. A simultaneous stall_f and redirect -> the redirect wins.
- PC_STATS_EN, 5 branches (2 taken) and 1 JAL -> stat_branches=5, stat_taken=3.
